mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer sharing one single-port unified memory between the pipeline's instruction-fetch port (read-only) and data-memory port (read/write). Sits between the datapath (`pc`/`instruction`, `alu_out`/`dmem_wd`/`dmem_rd`) and the physical memory. Arbitrates requests and sequences each access through a fixed-latency memory. Returns registered read data and a one-cycle done pulse, and drives per-port stall lines the control unit uses to freeze pipeline registers.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `LATENCY`, 1, cycles from `mem_en` high to `mem_rd` valid; legal range 1–15
- `MAX_DATA_STREAK`, 3, consecutive data grants allowed while fetch waits; legal range 1–15
- `clock`  in  1  sole clock; all state on rising edge
- `reset`  in  1  synchronous, active-high
- `f_req`  in  1  fetch request; held with `f_addr` until `f_done`
- `f_addr`  in  ADDR_W  fetch address
- `f_rdata`  out  DATA_W  last fetched word; registered
- `f_done`  out  1  one-cycle completion pulse
- `f_stall`  out  1  `f_req & ~f_done`, combinational
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wd` until `d_done`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wd`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  last data-read word; registered
- `d_done`  out  1  one-cycle completion pulse
- `d_stall`  out  1  `d_req & ~d_done`, combinational
- `mem_en`  out  1  access strobe, one cycle per access
- `mem_we`  out  1  write strobe, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  registered address
- `mem_wd`  out  DATA_W  registered write data
- `mem_rd`  in  DATA_W  read data, valid `LATENCY` cycles after `mem_en`

## Operation
- FSM states:
  - IDLE: arbitrate; on any request, latch owner, `we`, addr, wd → ISSUE.
  - ISSUE: `mem_en`=1 for exactly one cycle; load `lat_cnt`=`LATENCY`. Write → RESP. Read → WAIT.
  - WAIT: decrement `lat_cnt` each cycle. On the cycle `lat_cnt`=1, sample `mem_rd` into owner's rdata register → RESP.
  - RESP: pulse owner's done for one cycle → IDLE.
- Arbitration in IDLE:
  - Only one port requesting → that port wins.
  - Both requesting → data wins, unless `streak`=`MAX_DATA_STREAK`, in which case fetch wins.
- `streak` (4-bit):
  - Increments on a data grant while `f_req` is high.
  - Clears on a fetch grant, or on a data grant while `f_req` is low.
  - Saturates at `MAX_DATA_STREAK`.
- Write data is not captured into any rdata register. `d_rdata` changes only on a data read; `f_rdata` only on a fetch.
- Owner inputs are ignored after latching; mid-transaction changes have no effect.
- A request dropped before its done pulse still completes; the done pulse is still issued.
- `mem_we`=0 whenever `mem_en`=0. `mem_addr`/`mem_wd` hold their last values outside ISSUE.

## Timing
- Request first seen high in IDLE at cycle T:
  - `mem_en` at T+1.
  - Read: `mem_rd` sampled at T+1+`LATENCY`; done and new rdata visible at T+2+`LATENCY` (T+3 for `LATENCY`=1).
  - Write: done at T+2.
- IDLE follows RESP. A requester that sees done at cycle X and presents a new request at X+1 is arbitrated at X+1. Back-to-back read throughput is one access per `LATENCY`+3 cycles.
- A loser's stall stays high throughout the winner's transaction.
- Reset values: state=IDLE; `mem_en`, `mem_we`, `f_done`, `d_done` = 0; `mem_addr`, `mem_wd`, `f_rdata`, `d_rdata` = 0; `streak`=0; `lat_cnt`=0.
- Reset asserted in any state aborts the transaction. No done pulse is issued, and outputs take reset values at the next edge.

## Configuration
- `MEM_PORT_ARB_STATS_EN` defined: adds outputs `stat_f_grants`, `stat_d_grants`, `stat_conflicts` (32-bit each, wrapping, reset to 0).
  - `stat_f_grants` counts fetch grants.
  - `stat_d_grants` counts data grants.
  - `stat_conflicts` counts IDLE cycles with both requests high.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Single fetch, `LATENCY`=1: `f_req`=1, `f_addr`=0x40 at T, memory returns 0x2402_0005 → `mem_en`=1/`mem_we`=0/`mem_addr`=0x40 at T+1; `f_done`=1 and `f_rdata`=0x2402_0005 at T+3; `f_stall`=1 for T..T+2.
- Data write: `d_req`=1, `d_we`=1, `d_addr`=0x80, `d_wd`=0xDEAD_BEEF → `mem_en`=`mem_we`=1 with those values at T+1; `d_done` at T+2; `d_rdata` unchanged.
- Simultaneous requests: `f_req` and `d_req` both high at T → data serviced first (`d_done` at T+3), fetch issued at T+5; `f_rdata` valid at T+7.
- Starvation guard, `MAX_DATA_STREAK`=3: `f_req` held and data re-requesting continuously → grant order D, D, D, F, D.
- `LATENCY`=4 read, with `reset` pulsed during WAIT → no `d_done`, all outputs 0 next cycle. A fresh read after reset completes at T+6.
- With `MEM_PORT_ARB_STATS_EN`: run the simultaneous-request scenario → `stat_d_grants`=1, `stat_f_grants`=1, `stat_conflicts`=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter over one fixed-latency memory port; MEM_PORT_ARB_STATS_EN adds grant/conflict counters
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LATENCY = 1,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_done,
  output logic              f_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wd,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
`ifdef MEM_PORT_ARB_STATS_EN
  ,
  output logic [31:0]       stat_f_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic own_d, we_q, grant_d, req;
  logic [3:0] lat_cnt, streak;
  always_comb begin
    req = f_req | d_req;
    grant_d = d_req & ~(f_req & (streak == 4'(MAX_DATA_STREAK)));
    state_n = (state == IDLE) ? (req ? ISSUE : IDLE)
            : (state == ISSUE) ? (we_q ? RESP : WAIT)
            : (state == WAIT) ? ((lat_cnt == 4'd1) ? RESP : WAIT)
            : IDLE;
    mem_en = (state == ISSUE);
    mem_we = mem_en & we_q;
    f_done = (state == RESP) & ~own_d;
    d_done = (state == RESP) & own_d;
    f_stall = f_req & ~f_done;
    d_stall = d_req & ~d_done;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      own_d <= 1'b0;
      we_q <= 1'b0;
      lat_cnt <= '0;
      streak <= '0;
      mem_addr <= '0;
      mem_wd <= '0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        own_d <= grant_d;
        we_q <= grant_d & d_we;
        mem_addr <= grant_d ? d_addr : f_addr;
        if (grant_d) mem_wd <= d_wd;
        streak <= (grant_d & f_req) ? streak + 4'd1 : 4'd0;
      end
      if (state == ISSUE) lat_cnt <= 4'(LATENCY);
      if (state == WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
        if (lat_cnt == 4'd1 && own_d) d_rdata <= mem_rd;
        if (lat_cnt == 4'd1 && !own_d) f_rdata <= mem_rd;
      end
    end
  end
`ifdef MEM_PORT_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_f_grants <= '0;
      stat_d_grants <= '0;
      stat_conflicts <= '0;
    end else if (state == IDLE) begin
      stat_d_grants <= stat_d_grants + {31'd0, grant_d};
      stat_f_grants <= stat_f_grants + {31'd0, f_req & ~grant_d};
      stat_conflicts <= stat_conflicts + {31'd0, f_req & d_req};
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int L = 1;
  localparam int MAX = 3;
  localparam int LB = 4;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, f_req, d_req, d_we, f_done, d_done, f_stall, d_stall, mem_en, mem_we;
  logic [31:0] f_addr, d_addr, d_wd, f_rdata, d_rdata, mem_addr, mem_wd, mem_rd;
  logic b_reset, b_f_req, b_d_req, b_d_we, b_f_done, b_d_done, b_f_stall, b_d_stall, b_mem_en, b_mem_we;
  logic [31:0] b_f_addr, b_d_addr, b_d_wd, b_f_rdata, b_d_rdata, b_mem_addr, b_mem_wd, b_mem_rd;
`ifdef MEM_PORT_ARB_STATS_EN
  logic [31:0] stat_f_grants, stat_d_grants, stat_conflicts, b_sf, b_sd, b_sc;
`endif
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L), .MAX_DATA_STREAK(MAX)) dut (
    .clock(clock), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata),
    .f_done(f_done), .f_stall(f_stall), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wd(d_wd), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef MEM_PORT_ARB_STATS_EN
    , .stat_f_grants(stat_f_grants), .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
`endif
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LB), .MAX_DATA_STREAK(MAX)) dut_b (
    .clock(clock), .reset(b_reset), .f_req(b_f_req), .f_addr(b_f_addr), .f_rdata(b_f_rdata),
    .f_done(b_f_done), .f_stall(b_f_stall), .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr),
    .d_wd(b_d_wd), .d_rdata(b_d_rdata), .d_done(b_d_done), .d_stall(b_d_stall), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
`ifdef MEM_PORT_ARB_STATS_EN
    , .stat_f_grants(b_sf), .stat_d_grants(b_sd), .stat_conflicts(b_sc)
`endif
  );
  logic [31:0] memory [logic [31:0]];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return memory.exists(a) ? memory[a] : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction
  logic [31:0] pb [LB];
  always @(posedge clock) begin
    mem_rd <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'hxxxx_xxxx;
    pb[0] <= (b_mem_en && !b_mem_we) ? mem_word(b_mem_addr) : 32'hxxxx_xxxx;
    for (int i = 1; i < LB; i++) pb[i] <= pb[i-1];
  end
  assign b_mem_rd = pb[LB-1];
  int checks = 0, failures = 0;
  int m_streak = 0;
  logic [31:0] exp_f = '0, exp_d = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // One arbitration plus the winner's whole transaction, checked cycle by cycle.
  task automatic serve(input bit scramble, output bit got_d);
    bit win_d, rd, drop;
    int dur;
    logic [31:0] a, wd, rdat;
    win_d = d_req && !(f_req && m_streak == MAX);
    m_streak = (win_d && f_req) ? m_streak + 1 : 0;
    rd = !(win_d && d_we);
    a = win_d ? d_addr : f_addr;
    wd = d_wd;
    rdat = mem_word(a);
    dur = rd ? 2 + L : 2;
    got_d = 1'b0;
    drop = scramble && ($urandom_range(0, 2) == 0);
    for (int c = 0; c <= dur; c++) begin
      @(negedge clock);
      chk1("mem_en", mem_en, c == 1);
      if (c == 1) begin
        chk1("mem_we", mem_we, !rd);
        chk("mem_addr", mem_addr, a);
        if (!rd) begin
          chk("mem_wd", mem_wd, wd);
          memory[a] = wd;
        end
      end
      if (c == dur && rd) begin
        if (win_d) exp_d = rdat;
        else exp_f = rdat;
      end
      chk1("f_done", f_done, c == dur && !win_d);
      chk1("d_done", d_done, c == dur && win_d);
      chk1("f_stall", f_stall, f_req && !(c == dur && !win_d));
      chk1("d_stall", d_stall, d_req && !(c == dur && win_d));
      chk("f_rdata", f_rdata, exp_f);
      chk("d_rdata", d_rdata, exp_d);
      if (d_done) got_d = 1'b1;
      if (c < dur) begin
        @(posedge clock);
        #1;
        if (c == 0 && drop) begin
          if (win_d) begin
            d_addr = $urandom;
            d_wd = $urandom;
            d_we = 1'($urandom_range(0, 1));
            d_req = 1'($urandom_range(0, 1));
          end else begin
            f_addr = $urandom;
            f_req = 1'($urandom_range(0, 1));
          end
        end
      end
    end
  endtask
  bit gd;
  string order;
  initial begin
    reset = 1'b1; b_reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; f_addr = '0; d_addr = '0; d_wd = '0;
    b_f_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0; b_f_addr = '0; b_d_addr = '0; b_d_wd = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_f_done", f_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_f_rdata", f_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_b_mem_en", b_mem_en, 1'b0);
    chk("rst_b_d_rdata", b_d_rdata, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0; b_reset = 1'b0;
    // simultaneous requests: data first, then fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    f_req = 1'b1; f_addr = 32'h44;
    serve(1'b0, gd);
    chk1("sim_first_is_d", gd, 1'b1);
    @(posedge clock);
    #1;
    d_req = 1'b0;
    serve(1'b0, gd);
    chk1("sim_second_is_f", gd, 1'b0);
`ifdef MEM_PORT_ARB_STATS_EN
    chk("stat_d_grants", stat_d_grants, 32'd1);
    chk("stat_f_grants", stat_f_grants, 32'd1);
    chk("stat_conflicts", stat_conflicts, 32'd1);
`endif
    @(posedge clock);
    #1;
    f_req = 1'b0;
    // single fetch
    memory[32'h40] = 32'h2402_0005;
    f_req = 1'b1; f_addr = 32'h40;
    serve(1'b0, gd);
    chk("fetch_word", f_rdata, 32'h2402_0005);
    @(posedge clock);
    #1;
    f_req = 1'b0;
    // data write leaves d_rdata alone
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wd = 32'hDEAD_BEEF;
    serve(1'b0, gd);
    chk("write_keeps_d_rdata", d_rdata, mem_word(32'h100));
    @(posedge clock);
    #1;
    d_req = 1'b0; d_we = 1'b0;
    // starvation guard
    order = "";
    f_req = 1'b1; f_addr = 32'h48;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4C;
    for (int n = 0; n < 5; n++) begin
      serve(1'b0, gd);
      order = {order, gd ? "D" : "F"};
      @(posedge clock);
      #1;
      if (gd) begin
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15)) << 2;
        d_wd = $urandom;
      end else f_req = 1'b0;
    end
    checks++;
    assert (order == "DDDFD") else begin
      failures++;
      $error("FAIL grant_order observed=%s expected=DDDFD", order);
    end
    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      if (!f_req && $urandom_range(0, 1) == 1) begin
        f_req = 1'b1;
        f_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15)) << 2;
        d_wd = $urandom;
      end
      if (!f_req && !d_req) begin
        f_req = 1'b1;
        f_addr = 32'($urandom_range(0, 15)) << 2;
      end
      serve(1'b1, gd);
      @(posedge clock);
      #1;
      if (gd) d_req = 1'b0;
      else f_req = 1'b0;
    end
    f_req = 1'b0; d_req = 1'b0;
    // LATENCY=4 instance: reset during WAIT aborts the read
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h200;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk1("b_mem_en", b_mem_en, c == 1);
      chk1("b_d_done_pre", b_d_done, 1'b0);
      @(posedge clock);
      #1;
    end
    b_reset = 1'b1; b_d_req = 1'b0;
    @(negedge clock);
    chk1("b_d_done_wait", b_d_done, 1'b0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk1("b_abort_mem_en", b_mem_en, 1'b0);
    chk1("b_abort_mem_we", b_mem_we, 1'b0);
    chk1("b_abort_d_done", b_d_done, 1'b0);
    chk1("b_abort_f_done", b_f_done, 1'b0);
    chk("b_abort_mem_addr", b_mem_addr, 32'h0);
    chk("b_abort_mem_wd", b_mem_wd, 32'h0);
    chk("b_abort_d_rdata", b_d_rdata, 32'h0);
    chk("b_abort_f_rdata", b_f_rdata, 32'h0);
    @(posedge clock);
    #1;
    b_reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk1("b_no_done", b_d_done, 1'b0);
    end
    @(posedge clock);
    #1;
    b_d_req = 1'b1; b_d_addr = 32'h204;
    for (int c = 0; c <= 2 + LB; c++) begin
      @(negedge clock);
      chk1("b_fresh_mem_en", b_mem_en, c == 1);
      chk1("b_fresh_d_done", b_d_done, c == 2 + LB);
      chk("b_fresh_d_rdata", b_d_rdata, (c == 2 + LB) ? mem_word(32'h204) : 32'h0);
      @(posedge clock);
      #1;
      if (c == 0) b_d_req = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
